// File: rtl/tt_um_alu_sequencer.sv
// rtl/tt_um_alu_sequencer.sv - command-queue ALU sequencer with 4-deep FIFO and restoring divider
module tt_um_alu_sequencer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  typedef enum logic [1:0] {IDLE, FETCH, EXEC, DIV} state_t;
  state_t state, state_nxt;

  logic       push_q, start_q;
  logic [5:0] fifo [4];
  logic [1:0] wr_ptr, rd_ptr;
  logic [2:0] count;
  logic [1:0] op_r;
  logic [3:0] b_r;
  logic [7:0] acc;
  logic       err;
  logic [7:0] rem, quo;
  logic [2:0] iter;

  logic push_ev, start_ev, full, empty, pop, push_ok, more_cmds, clear_ok;
  logic div_zero, div_ge;
  logic [8:0] rem_sh, rem_nxt;
  logic [7:0] quo_nxt;

  assign push_ev  = ui_in[6] & ~push_q;
  assign start_ev = uio_in[0] & ~start_q;
  assign full     = (count == 3'd4);
  assign empty    = (count == 3'd0);
  assign pop      = (state == FETCH) && !empty;
  // A pop on the same edge frees a slot, so a push into a full queue still lands.
  assign push_ok  = push_ev && (!full || pop);
  // An empty queue always accepts a push, so this covers a push landing this edge.
  assign more_cmds = !empty || push_ev;
  assign clear_ok  = uio_in[1] && (state == IDLE);
  assign div_zero  = (op_r == 2'b11) && (b_r == 4'd0);

  assign rem_sh  = {rem, quo[7]};
  assign div_ge  = (rem_sh >= {5'd0, b_r});
  assign rem_nxt = div_ge ? (rem_sh - {5'd0, b_r}) : rem_sh;
  assign quo_nxt = {quo[6:0], div_ge};

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start_ev && !empty) state_nxt = FETCH;
      FETCH: state_nxt = EXEC;
      EXEC: begin
        if (op_r == 2'b11 && !div_zero) state_nxt = DIV;
        else                            state_nxt = more_cmds ? FETCH : IDLE;
      end
      DIV:   if (iter == 3'd7) state_nxt = more_cmds ? FETCH : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push_ok) fifo[wr_ptr] <= {ui_in[5:4], ui_in[3:0]};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      push_q  <= 1'b0;
      start_q <= 1'b0;
      wr_ptr  <= 2'd0;
      rd_ptr  <= 2'd0;
      count   <= 3'd0;
      op_r    <= 2'd0;
      b_r     <= 4'd0;
      acc     <= 8'd0;
      err     <= 1'b0;
      rem     <= 8'd0;
      quo     <= 8'd0;
      iter    <= 3'd0;
    end else begin
      state   <= state_nxt;
      push_q  <= ui_in[6];
      start_q <= uio_in[0];

      if (push_ok) wr_ptr <= wr_ptr + 2'd1;
      if (pop) begin
        rd_ptr <= rd_ptr + 2'd1;
        op_r   <= fifo[rd_ptr][5:4];
        b_r    <= fifo[rd_ptr][3:0];
      end
      case ({push_ok, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase

      if (clear_ok) begin
        acc <= 8'd0;
        err <= 1'b0;
      end
      if (push_ev && !push_ok) err <= 1'b1;

      if (state == EXEC) begin
        case (op_r)
          2'b00: acc <= acc + {4'd0, b_r};
          2'b01: acc <= acc * {4'd0, b_r};
          2'b10: acc <= acc - {4'd0, b_r};
          default: begin
            if (div_zero) begin
              acc <= 8'hFF;
              err <= 1'b1;
            end else begin
              rem  <= 8'd0;
              quo  <= acc;
              iter <= 3'd0;
            end
          end
        endcase
      end

      // Divider state stays internal; acc only sees the finished quotient.
      if (state == DIV) begin
        rem  <= rem_nxt[7:0];
        quo  <= quo_nxt;
        iter <= iter + 3'd1;
        if (iter == 3'd7) acc <= quo_nxt;
      end
    end
  end

  assign uo_out  = acc;
  assign uio_out = {(state != IDLE), full, empty, err, 4'b0000};
  assign uio_oe  = 8'hF0;

  logic unused_ok;
  assign unused_ok = &{1'b0, ena, ui_in[7], uio_in[7:2]};

endmodule

// File: tb/tb_tt_um_alu_sequencer.sv
// tb/tb_tt_um_alu_sequencer.sv - self-checking bench with a queue-based reference model
module tb_tt_um_alu_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic [7:0] ui_in = 8'h00;
  logic [7:0] uio_in = 8'h00;
  logic [7:0] uo_out, uio_out, uio_oe;

  always #5 clk = ~clk;

  tt_um_alu_sequencer dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
    .uo_out(uo_out), .uio_out(uio_out), .uio_oe(uio_oe)
  );

  int checks = 0;
  int failures = 0;

  logic [7:0] acc_m;
  logic       err_m;
  logic [5:0] q_m[$];
  int         cyc_m;

  task automatic step;
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [1:0] op, input logic [3:0] b);
    ui_in = {1'b0, 1'b1, op, b};
    step;
    ui_in[6] = 1'b0;
    step;
    if (q_m.size() < 4) q_m.push_back({op, b});
    else                err_m = 1'b1;
  endtask

  task automatic clear_acc;
    uio_in[1] = 1'b1;
    step;
    uio_in[1] = 1'b0;
    acc_m = 8'h00;
    err_m = 1'b0;
  endtask

  task automatic model_run;
    logic [5:0] c;
    int a, b;
    cyc_m = 0;
    while (q_m.size() > 0) begin
      c = q_m.pop_front();
      a = int'(acc_m);
      b = int'(c[3:0]);
      case (c[5:4])
        2'b00: begin acc_m = 8'((a + b) % 256);       cyc_m += 2; end
        2'b01: begin acc_m = 8'((a * b) % 256);       cyc_m += 2; end
        2'b10: begin acc_m = 8'((a - b + 256) % 256); cyc_m += 2; end
        default: begin
          if (b == 0) begin acc_m = 8'hFF; err_m = 1'b1; cyc_m += 2; end
          else        begin acc_m = 8'(a / b);          cyc_m += 10; end
        end
      endcase
    end
  endtask

  task automatic run_batch(input string tag);
    int cycles;
    model_run();
    uio_in[0] = 1'b1;
    step;
    uio_in[0] = 1'b0;
    cycles = 0;
    while (uio_out[7] === 1'b1 && cycles < 500) begin
      cycles++;
      step;
    end
    check({tag, " busy_cycles"}, 8'(cycles), 8'(cyc_m));
    check({tag, " acc"}, uo_out, acc_m);
    check({tag, " status"}, uio_out, {3'b001, err_m, 4'b0000});
  endtask

  initial begin
    acc_m = 8'h00;
    err_m = 1'b0;

    // Reset
    step; step;
    check("reset uo_out", uo_out, 8'h00);
    check("reset uio_out", uio_out, 8'h20);
    check("reset uio_oe", uio_oe, 8'hF0);
    rst_n = 1'b1;
    step;

    // add 5, add 3, mul 4 -> 0x20 in 6 busy cycles
    clear_acc();
    push(2'b00, 4'd5);
    push(2'b00, 4'd3);
    push(2'b01, 4'd4);
    run_batch("basic");
    check("basic literal", uo_out, 8'h20);

    // sub wrap and mul truncation
    clear_acc();
    push(2'b00, 4'd2);
    run_batch("acc2");
    push(2'b10, 4'd5);
    run_batch("sub5");
    check("sub5 literal", uo_out, 8'hFD);
    push(2'b01, 4'd15);
    run_batch("mul15");
    check("mul15 literal", uo_out, 8'hD3);

    // 100 / 7 timing: acc holds for 9 samples, quotient on the 10th edge
    clear_acc();
    for (int i = 0; i < 4; i++) push(2'b00, 4'd15);
    run_batch("build60");
    push(2'b00, 4'd15);
    push(2'b00, 4'd15);
    push(2'b00, 4'd10);
    run_batch("build100");
    check("build100 literal", uo_out, 8'd100);
    push(2'b11, 4'd7);
    q_m.delete();
    uio_in[0] = 1'b1;
    step;
    uio_in[0] = 1'b0;
    for (int i = 0; i < 9; i++) begin
      check("div hold", uo_out, 8'd100);
      step;
    end
    check("div busy before end", {7'd0, uio_out[7]}, 8'd1);
    step;
    check("div quotient", uo_out, 8'h0E);
    check("div busy after end", {7'd0, uio_out[7]}, 8'd0);
    acc_m = 8'h0E;

    // divide by zero: FF and sticky err two edges after start
    push(2'b11, 4'd0);
    q_m.delete();
    uio_in[0] = 1'b1;
    step;
    uio_in[0] = 1'b0;
    step;
    step;
    check("div0 acc", uo_out, 8'hFF);
    check("div0 status", uio_out, 8'h30);
    acc_m = 8'hFF;
    err_m = 1'b1;
    push(2'b00, 4'd1);
    run_batch("err sticky");
    clear_acc();
    check("clear status", uio_out, 8'h20);
    check("clear acc", uo_out, 8'h00);

    // overflow: fifth push dropped, err set, exactly 4 commands run
    for (int i = 0; i < 4; i++) push(2'b00, 4'(i + 1));
    check("full after 4", uio_out, 8'h40);
    push(2'b00, 4'd9);
    check("overflow status", uio_out, 8'h50);
    run_batch("overflow run");
    check("overflow literal", uo_out, 8'd10);

    // push landing on the final EXEC edge joins the batch
    clear_acc();
    push(2'b00, 4'd1);
    q_m.delete();
    uio_in[0] = 1'b1;
    step;
    uio_in[0] = 1'b0;
    step;
    ui_in = {1'b0, 1'b1, 2'b00, 4'd2};
    step;
    ui_in[6] = 1'b0;
    begin
      int cycles;
      cycles = 0;
      while (uio_out[7] === 1'b1 && cycles < 100) begin
        cycles++;
        step;
      end
      check("late push cycles", 8'(cycles), 8'd2);
    end
    check("late push acc", uo_out, 8'd3);
    check("late push status", uio_out, 8'h20);
    acc_m = 8'd3;

    // randomized batches against the model
    for (int it = 0; it < 25; it++) begin
      int n;
      if ($urandom_range(0, 3) == 0) clear_acc();
      n = $urandom_range(1, 5);
      for (int k = 0; k < n; k++)
        push(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));
      check("rand full", {7'd0, uio_out[6]}, {7'd0, (q_m.size() == 4)});
      run_batch("rand");
    end

    // reset in the middle of a divide
    push(2'b11, 4'd3);
    uio_in[0] = 1'b1;
    step;
    uio_in[0] = 1'b0;
    step; step; step; step;
    rst_n = 1'b0;
    step;
    rst_n = 1'b1;
    check("mid reset acc", uo_out, 8'h00);
    check("mid reset status", uio_out, 8'h20);
    uio_in[0] = 1'b1;
    step;
    uio_in[0] = 1'b0;
    step;
    check("empty start ignored", uio_out, 8'h20);
    check("empty start acc", uo_out, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
